multi_channel_sequencer: RTL and testbench

Time-multiplexed, parametrised note sequencer: one instance serves `CHANNELS` independent voice patterns from a single shared synchronous pattern ROM. On each note strobe it visits every channel in order, advances that channel's duration counter, and fetches and emits a new note event when the current note expires. It sits between the tempo divider (strobe source) and the per-voice oscillator/envelope blocks, and replaces single-channel sequencers with per-channel pattern base, length and looping.

---
 rtl/multi_channel_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_multi_channel_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_sequencer.sv
// Time-multiplexed note sequencer: CHANNELS voices share one synchronous pattern ROM.
// Optional SEQ_MUTE_EN adds i_mute to suppress per-channel note pulses.
module multi_channel_sequencer #(
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 8,
    parameter int LEN_W    = 5
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_note_stb,
    input  logic                        i_load_valid,
    input  logic [$clog2(CHANNELS)-1:0] i_load_chan,
    input  logic [ADDR_W-1:0]           i_load_base,
    input  logic [LEN_W-1:0]            i_load_len,
`ifdef SEQ_MUTE_EN
    input  logic [CHANNELS-1:0]         i_mute,
`endif
    output logic [ADDR_W-1:0]           o_rom_addr,
    input  logic [15:0]                 i_rom_data,
    output logic                        o_note_valid,
    output logic [$clog2(CHANNELS)-1:0] o_note_chan,
    output logic [5:0]                  o_note,
    output logic [LEN_W-1:0]            o_note_len,
    output logic [3:0]                  o_instrument,
    output logic                        o_busy,
    output logic                        o_overrun
);
    localparam int CW = $clog2(CHANNELS);
    localparam logic [1:0] S_IDLE = 2'd0, S_SCAN = 2'd1, S_FETCH = 2'd2, S_DATA = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] chan_q, chan_d;
    logic [CHANNELS-1:0][ADDR_W-1:0] base_q, base_d, stg_base_q, stg_base_d;
    logic [CHANNELS-1:0][LEN_W-1:0]  len_q, len_d, idx_q, idx_d, cnt_q, cnt_d, nlen_q, nlen_d;
    logic [CHANNELS-1:0][LEN_W-1:0]  stg_len_q, stg_len_d;
    logic [CHANNELS-1:0]             pend_q, pend_d, stg_vld_q, stg_vld_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              note_valid_q, note_valid_d, overrun_q, overrun_d;
    logic [CW-1:0]     note_chan_q, note_chan_d;
    logic [5:0]        note_q, note_d;
    logic [LEN_W-1:0]  note_len_q, note_len_d;
    logic [3:0]        instr_q, instr_d;

    // effective per-channel values in SCAN, after any staged load is applied
    logic [ADDR_W-1:0] base_e;
    logic [LEN_W-1:0]  len_e, idx_e, cnt_e;
    logic              pend_e, last_chan;
    logic              unused_rom_bit;

    assign unused_rom_bit = i_rom_data[15];
    assign last_chan      = (chan_q == CW'(CHANNELS - 1));

    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        base_d       = base_q;
        len_d        = len_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        nlen_d       = nlen_q;
        pend_d       = pend_q;
        stg_vld_d    = stg_vld_q;
        stg_base_d   = stg_base_q;
        stg_len_d    = stg_len_q;
        rom_addr_d   = rom_addr_q;
        note_valid_d = 1'b0;
        note_chan_d  = note_chan_q;
        note_d       = note_q;
        note_len_d   = note_len_q;
        instr_d      = instr_q;
        overrun_d    = i_note_stb && (state_q != S_IDLE);
        base_e       = base_q[chan_q];
        len_e        = len_q[chan_q];
        idx_e        = idx_q[chan_q];
        cnt_e        = cnt_q[chan_q];
        pend_e       = pend_q[chan_q];

        case (state_q)
            S_IDLE: begin
                if (i_note_stb) begin
                    chan_d  = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (stg_vld_q[chan_q]) begin
                    base_e = stg_base_q[chan_q];
                    len_e  = stg_len_q[chan_q];
                    idx_e  = '0;
                    cnt_e  = '0;
                    pend_e = 1'b1;
                    stg_vld_d[chan_q] = 1'b0;
                end
                base_d[chan_q] = base_e;
                len_d[chan_q]  = len_e;
                idx_d[chan_q]  = idx_e;
                cnt_d[chan_q]  = cnt_e;
                pend_d[chan_q] = pend_e;
                if (len_e != '0 && (pend_e || cnt_e == nlen_q[chan_q])) begin
                    rom_addr_d = base_e + ADDR_W'(idx_e);
                    state_d    = S_FETCH;
                end else begin
                    if (len_e != '0) cnt_d[chan_q] = cnt_e + LEN_W'(1);
                    if (last_chan) state_d = S_IDLE;
                    else           chan_d  = chan_q + CW'(1);
                end
            end
            S_FETCH: state_d = S_DATA;
            default: begin
                note_d      = i_rom_data[5:0];
                note_len_d  = LEN_W'(i_rom_data[10:6]);
                instr_d     = i_rom_data[14:11];
                note_chan_d = chan_q;
`ifdef SEQ_MUTE_EN
                note_valid_d = !i_mute[chan_q];
`else
                note_valid_d = 1'b1;
`endif
                nlen_d[chan_q] = LEN_W'(i_rom_data[10:6]);
                cnt_d[chan_q]  = '0;
                pend_d[chan_q] = 1'b0;
                if (idx_q[chan_q] == len_q[chan_q] - LEN_W'(1)) idx_d[chan_q] = '0;
                else idx_d[chan_q] = idx_q[chan_q] + LEN_W'(1);
                if (last_chan) state_d = S_IDLE;
                else begin
                    chan_d  = chan_q + CW'(1);
                    state_d = S_SCAN;
                end
            end
        endcase

        // capture after the SCAN clear so a same-cycle load survives to the next tick
        if (i_load_valid && int'(i_load_chan) < CHANNELS) begin
            stg_vld_d[i_load_chan]  = 1'b1;
            stg_base_d[i_load_chan] = i_load_base;
            stg_len_d[i_load_chan]  = i_load_len;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            chan_q       <= '0;
            base_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            nlen_q       <= '0;
            pend_q       <= '0;
            stg_vld_q    <= '0;
            stg_base_q   <= '0;
            stg_len_q    <= '0;
            rom_addr_q   <= '0;
            note_valid_q <= 1'b0;
            note_chan_q  <= '0;
            note_q       <= '0;
            note_len_q   <= '0;
            instr_q      <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            chan_q       <= chan_d;
            base_q       <= base_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            nlen_q       <= nlen_d;
            pend_q       <= pend_d;
            stg_vld_q    <= stg_vld_d;
            stg_base_q   <= stg_base_d;
            stg_len_q    <= stg_len_d;
            rom_addr_q   <= rom_addr_d;
            note_valid_q <= note_valid_d;
            note_chan_q  <= note_chan_d;
            note_q       <= note_d;
            note_len_q   <= note_len_d;
            instr_q      <= instr_d;
            overrun_q    <= overrun_d;
        end
    end

    assign o_rom_addr   = rom_addr_q;
    assign o_note_valid = note_valid_q;
    assign o_note_chan  = note_chan_q;
    assign o_note       = note_q;
    assign o_note_len   = note_len_q;
    assign o_instrument = instr_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_overrun    = overrun_q;
endmodule

// File: tb/tb_multi_channel_sequencer.sv
// Directed bench for multi_channel_sequencer (4 channels) with a synchronous ROM model.
module tb_multi_channel_sequencer;
    logic        clk = 1'b0;
    logic        rst, stb, ld_v;
    logic [1:0]  ld_ch;
    logic [7:0]  ld_base;
    logic [4:0]  ld_len;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        nv, busy, ovr;
    logic [1:0]  nch;
    logic [5:0]  note;
    logic [4:0]  nlen;
    logic [3:0]  instr;
`ifdef SEQ_MUTE_EN
    logic [3:0]  mute = 4'b0;
`endif
    logic [15:0] rom [256];

    int total = 0, bad = 0;
    int ev_n, busy_n, ovr_n, ovr_k;
    int ev_k [16];
    int ev_ch [16];
    int ev_note [16];
    int ev_len [16];

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    multi_channel_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_note_stb(stb),
        .i_load_valid(ld_v), .i_load_chan(ld_ch), .i_load_base(ld_base), .i_load_len(ld_len),
`ifdef SEQ_MUTE_EN
        .i_mute(mute),
`endif
        .o_rom_addr(rom_addr), .i_rom_data(rom_data),
        .o_note_valid(nv), .o_note_chan(nch), .o_note(note), .o_note_len(nlen),
        .o_instrument(instr), .o_busy(busy), .o_overrun(ovr));

    function automatic logic [15:0] w(input int n, input int l, input int ins);
        return {1'b0, 4'(ins), 5'(l), 6'(n)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_ch(input int ch, input int base, input int len);
        ld_v = 1'b1; ld_ch = 2'(ch); ld_base = 8'(base); ld_len = 5'(len);
        @(negedge clk);
        ld_v = 1'b0;
    endtask

    // one strobe, then 16 bounded cycles of observation; 'extra' re-strobes at that offset
    task automatic scan(input int extra);
        ev_n = 0; busy_n = 0; ovr_n = 0; ovr_k = 0;
        stb = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (nv) begin
                if (ev_n < 16) begin
                    ev_k[ev_n] = k; ev_ch[ev_n] = int'(nch);
                    ev_note[ev_n] = int'(note); ev_len[ev_n] = int'(nlen);
                end
                ev_n++;
            end
            if (busy) busy_n++;
            if (ovr) begin ovr_n++; ovr_k = k; end
            stb = (k == extra);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"}, 32'(rom_addr), 0);
        check({tag, "_valid"}, 32'(nv), 0);
        check({tag, "_chan"}, 32'(nch), 0);
        check({tag, "_note"}, 32'(note), 0);
        check({tag, "_len"}, 32'(nlen), 0);
        check({tag, "_instr"}, 32'(instr), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_ovr"}, 32'(ovr), 0);
    endtask

    initial begin
        int notes_a [4] = '{1, 2, 3, 1};
        int addrs_a [4] = '{8'h10, 8'h11, 8'h12, 8'h10};
        int notes_e [5] = '{10, 11, 12, 13, 10};
        int addrs_e [5] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'hFE};
        int evs_b   [4] = '{1, 0, 0, 1};
        for (int i = 0; i < 256; i++) rom[i] = 16'h0;
        rom[8'h10] = w(1, 0, 1); rom[8'h11] = w(2, 0, 2); rom[8'h12] = w(3, 0, 3);
        rom[8'h20] = w(5, 2, 4);
        rom[8'h30] = w(7, 0, 5); rom[8'h40] = w(8, 0, 6); rom[8'h50] = w(9, 0, 7);
        rom[8'hFE] = w(10, 0, 1); rom[8'hFF] = w(11, 0, 1);
        rom[8'h00] = w(12, 0, 1); rom[8'h01] = w(13, 0, 1);
        rst = 1'b1; stb = 1'b0; ld_v = 1'b0; ld_ch = '0; ld_base = '0; ld_len = '0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // ch0 cycles through a 3-word pattern, one note per strobe
        load_ch(0, 8'h10, 3);
        for (int s = 0; s < 4; s++) begin
            scan(0);
            check($sformatf("a%0d_count", s), ev_n, 1);
            check($sformatf("a%0d_cyc", s), ev_k[0], 4);
            check($sformatf("a%0d_chan", s), ev_ch[0], 0);
            check($sformatf("a%0d_note", s), ev_note[0], notes_a[s]);
            check($sformatf("a%0d_addr", s), 32'(rom_addr), addrs_a[s]);
        end

        // ch1 note of length 2 holds for 3 strobes
        load_ch(0, 0, 0);
        load_ch(1, 8'h20, 1);
        for (int s = 0; s < 4; s++) begin
            scan(0);
            check($sformatf("b%0d_count", s), ev_n, evs_b[s]);
        end
        check("b_note", 32'(note), 5);
        check("b_len", 32'(nlen), 2);
        check("b_instr", 32'(instr), 4);

        // all four channels fetch in one scan
        load_ch(0, 8'h10, 3); load_ch(1, 8'h30, 1); load_ch(2, 8'h40, 1); load_ch(3, 8'h50, 1);
        scan(0);
        check("c_count", ev_n, 4);
        check("c_busy", busy_n, 12);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("c_cyc%0d", i), ev_k[i], 4 + 3 * i);
            check($sformatf("c_chan%0d", i), ev_ch[i], i);
            check($sformatf("c_note%0d", i), ev_note[i], i == 0 ? 1 : 6 + i);
        end

        // dropped strobe mid-scan
        scan(5);
        check("d_ovr_n", ovr_n, 1);
        check("d_ovr_k", ovr_k, 6);
        check("d_count", ev_n, 4);
        check("d_busy", busy_n, 12);
        for (int i = 0; i < 4; i++) check($sformatf("d_note%0d", i), ev_note[i], i == 0 ? 2 : 6 + i);
        scan(0);
        check("d2_ovr_n", ovr_n, 0);
        check("d2_count", ev_n, 4);
        for (int i = 0; i < 4; i++) check($sformatf("d2_cyc%0d", i), ev_k[i], 4 + 3 * i);
        check("d2_note0", ev_note[0], 3);

        // address wrap at 2^ADDR_W, then disable mid-pattern
        load_ch(0, 0, 0); load_ch(1, 0, 0); load_ch(3, 0, 0);
        load_ch(2, 8'hFE, 4);
        for (int s = 0; s < 5; s++) begin
            scan(0);
            check($sformatf("e%0d_count", s), ev_n, 1);
            check($sformatf("e%0d_cyc", s), ev_k[0], 6);
            check($sformatf("e%0d_chan", s), ev_ch[0], 2);
            check($sformatf("e%0d_note", s), ev_note[0], notes_e[s]);
            check($sformatf("e%0d_addr", s), 32'(rom_addr), addrs_e[s]);
        end
        load_ch(2, 0, 0);
        scan(0);
        check("e_off_count", ev_n, 0);
        scan(0);
        check("e_off_count2", ev_n, 0);

        // reset while the ROM fetch is outstanding
        load_ch(0, 8'h10, 3);
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        @(negedge clk);
        check("f_busy_pre", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check_idle_outputs("f_rst");
        @(negedge clk);
        rst = 1'b0;
        ev_n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (nv) ev_n++;
        end
        check("f_no_event", ev_n, 0);
        scan(0);
        check("f_disabled", ev_n, 0);

`ifdef SEQ_MUTE_EN
        load_ch(0, 8'h10, 3);
        mute = 4'b0001;
        scan(0);
        check("m0_count", ev_n, 0);
        check("m0_note", 32'(note), 1);
        scan(0);
        check("m1_count", ev_n, 0);
        check("m1_addr", 32'(rom_addr), 8'h11);
        mute = 4'b0000;
        scan(0);
        check("m2_count", ev_n, 1);
        check("m2_note", ev_note[0], 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
